// File: rtl/ex_divider_pkg.sv
// Shared definitions for the EX-stage integer divider.
//   DATA_BUS          : width of the integer data bus
//   div_state_e       : divider FSM encodings (DIV_IDLE / DIV_BUSY / DIV_DONE)
//   DIV_ZERO_QUOTIENT : quotient returned for a zero divisor
package ex_divider_pkg;

   localparam int DATA_BUS = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam logic [DATA_BUS-1:0] DIV_ZERO_QUOTIENT = 32'hffff_ffff;

endpackage

// File: rtl/ex_divider_div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial
// subtract the divisor from the partial remainder, keep the difference and
// set the new quotient bit when it does not go negative.
//   rem_in / quo_in   : partial remainder and dividend/quotient shift register
//   divisor           : divisor magnitude
//   rem_out / quo_out : values after this step
module ex_divider_div_step
   import ex_divider_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_BUS
) (
   input  logic [DATA_WIDTH-1:0] rem_in,
   input  logic [DATA_WIDTH-1:0] quo_in,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] rem_out,
   output logic [DATA_WIDTH-1:0] quo_out
);

   logic [DATA_WIDTH:0] rem_shift;
   logic [DATA_WIDTH:0] diff;

   // The shifted remainder can exceed DATA_WIDTH bits, so the trial subtract
   // is one bit wider. Because rem_shift < 2*divisor, the top bit of the
   // difference is a reliable borrow flag.
   always_comb begin
      rem_shift = {rem_in, quo_in[DATA_WIDTH-1]};
      diff      = rem_shift - {1'b0, divisor};
      if (!diff[DATA_WIDTH]) begin
         rem_out = diff[DATA_WIDTH-1:0];
         quo_out = {quo_in[DATA_WIDTH-2:0], 1'b1};
      end else begin
         rem_out = rem_shift[DATA_WIDTH-1:0];
         quo_out = {quo_in[DATA_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_divider.sv
// Multi-cycle DIV/DIVU unit for the EX stage. Divides magnitudes with one
// restoring step per cycle and applies signs on the way out. Requests a
// pipeline stall while a division is in flight.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : abort any division, return to IDLE
//   stall_all     : hold the DONE result while the pipeline is frozen
//   start         : EX holds a DIV/DIVU (kept high while EX stalls)
//   is_signed     : 1 = DIV, 0 = DIVU
//   operand_a/b   : dividend / divisor, sampled with start in IDLE
//   stall_request : combinational stall request to the controller
//   done          : result valid this cycle
//   result_hi/lo  : remainder / quotient
module ex_divider
   import ex_divider_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_BUS,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  stall_all,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic                  stall_request,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result_hi,
   output logic [DATA_WIDTH-1:0] result_lo
);

   localparam logic [CNT_WIDTH-1:0]  CNT_LAST    = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] ZERO_DIV_QUO = DATA_WIDTH'(DIV_ZERO_QUOTIENT);

   function automatic logic [DATA_WIDTH-1:0] cond_negate(
      input logic [DATA_WIDTH-1:0] value,
      input logic                  neg
   );
      return neg ? -value : value;
   endfunction

   div_state_e            state;
   div_state_e            state_next;
   logic [CNT_WIDTH-1:0]  counter;

   logic [DATA_WIDTH-1:0] rem;
   logic [DATA_WIDTH-1:0] quo;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  neg_quo;
   logic                  neg_rem;

   logic [DATA_WIDTH-1:0] step_rem;
   logic [DATA_WIDTH-1:0] step_quo;

   logic                  sign_a;
   logic                  sign_b;
   logic                  accept;

   assign sign_a = is_signed & operand_a[DATA_WIDTH-1];
   assign sign_b = is_signed & operand_b[DATA_WIDTH-1];
   assign accept = (state == DIV_IDLE) & start & ~flush;

   ex_divider_div_step #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_div_step (
      .rem_in (rem),
      .quo_in (quo),
      .divisor(divisor),
      .rem_out(step_rem),
      .quo_out(step_quo)
   );

   // State register and iteration counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_IDLE;
         counter <= '0;
      end else begin
         state <= state_next;
         if (state == DIV_BUSY) begin
            counter <= counter + 1'b1;
         end else begin
            counter <= '0;
         end
      end
   end

   // Next-state logic; flush overrides everything, and a dropped start
   // in BUSY means the instruction left EX, so the division is abandoned.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  state_next = (operand_b == '0) ? DIV_DONE : DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               if (!start) begin
                  state_next = DIV_IDLE;
               end else if (counter == CNT_LAST) begin
                  state_next = DIV_DONE;
               end
            end
            DIV_DONE: begin
               if (!stall_all) begin
                  state_next = DIV_IDLE;
               end
            end
            default: state_next = DIV_IDLE;
         endcase
      end
   end

   // Datapath registers; outputs are gated by state, so no reset is needed.
   // A zero divisor loads the final results directly with no sign fix-up.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (operand_b == '0) begin
            quo     <= ZERO_DIV_QUO;
            rem     <= operand_a;
            divisor <= operand_b;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
         end else begin
            quo     <= cond_negate(operand_a, sign_a);
            rem     <= '0;
            divisor <= cond_negate(operand_b, sign_b);
            neg_quo <= sign_a ^ sign_b;
            neg_rem <= sign_a;
         end
      end else if (state == DIV_BUSY) begin
         rem <= step_rem;
         quo <= step_quo;
      end
   end

   // Outputs
   always_comb begin
      done          = (state == DIV_DONE);
      result_lo     = '0;
      result_hi     = '0;
      stall_request = start & (state != DIV_DONE) & ~flush;
      if (state == DIV_DONE) begin
         result_lo = cond_negate(quo, neg_quo);
         result_hi = cond_negate(rem, neg_rem);
      end
   end

endmodule

// File: doc/ex_divider.md
Name: ex_divider

Overview:
- Multi-cycle 32-bit integer divider in the EX stage for DIV/DIVU.
- Acts as the requester side of the pipeline stall protocol. It raises stall_request, which drives the controller's request_from_ex, while a division is in flight.
- It obeys the controller's flush and global stall_all outputs.
- Results go to the HI/LO write path (remainder to HI, quotient to LO).

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2^CNT_WIDTH = DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  exception flush from the pipeline controller; aborts any division.
- stall_all  input  1  whole-pipeline stall from the controller; holds the DONE result.
- start  input  1  EX holds a valid DIV/DIVU; held high while EX is stalled.
- is_signed  input  1  1 = DIV, 0 = DIVU; sampled with start in IDLE.
- operand_a  input  DATA_WIDTH  dividend; sampled with start in IDLE.
- operand_b  input  DATA_WIDTH  divisor; sampled with start in IDLE.
- stall_request  output  1  to the controller's request_from_ex; combinational.
- done  output  1  result valid this cycle.
- result_hi  output  DATA_WIDTH  remainder.
- result_lo  output  DATA_WIDTH  quotient.

Behaviour:
- Reset:
  - state = IDLE, counter = 0.
  - done = 0, result_hi = 0, result_lo = 0.
  - stall_request = 0.
  - Reset mid-operation discards all internal state.
- States: IDLE, BUSY, DONE.
- IDLE:
  - When start=1 and flush=0: latch |a| and |b| (unsigned: raw values), latch the quotient sign (sign_a ^ sign_b, signed only) and remainder sign (sign_a, signed only).
  - Then clear the partial remainder, set counter = 0 and go to BUSY.
  - If operand_b = 0, go straight to DONE instead. The result is quotient = all-ones and remainder = operand_a, in both signed and unsigned modes.
- BUSY (one restoring step per cycle):
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem - |b|, computed DATA_WIDTH+1 bits wide.
  - If the result is non-negative, rem = difference and quo[0] = 1.
  - counter increments; on counter = 31, go to DONE.
- DONE:
  - done = 1.
  - result_lo = quotient, negated if the quotient sign is set.
  - result_hi = remainder, negated if the remainder sign is set.
  - If stall_all = 0, go to IDLE next cycle. If stall_all = 1, hold DONE with the results stable.
- stall_request = start & (state != DONE) & ~flush.
  - It is high in the start cycle and throughout BUSY, and low in DONE so EX advances.
- Latency: with start sampled at cycle 0, BUSY covers cycles 1–32 and DONE is cycle 33. stall_request is high for cycles 0–32 (33 cycles).
- Divide-by-zero latency: start at cycle 0, DONE at cycle 1; stall_request is high for 1 cycle.
- flush=1 in any state: next state is IDLE with done = 0. stall_request is 0 in the same cycle. flush has priority over start.
- start drops in BUSY (instruction gone without flush): abort to IDLE next cycle.
- stall_all during BUSY: iteration continues. Only the DONE exit is gated by stall_all.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This falls out of the magnitude datapath and needs no special case.
- Back-to-back: a new start is accepted only in IDLE. There is a minimum of 1 IDLE cycle between divisions.

Decomposition:
- Shared bus package (bus.v) gets:
  - state encodings DIV_IDLE / DIV_BUSY / DIV_DONE;
  - the DIV_ZERO_QUOTIENT constant (32'hffff_ffff);
  - reuse of the existing DATA_BUS define.
- One natural sub-module: div_step, the combinational shift/trial-subtract for a single iteration.
- Sign conditioning and final negation stay in ex_divider.

Test Plan:
- Unsigned divide: start with is_signed=0, a=100, b=7.
  - stall_request high for exactly 33 cycles.
  - done in cycle 33 with result_lo=14, result_hi=2.
- Signed divide: a=-100 (0xFFFFFF9C), b=7.
  - result_lo=0xFFFFFFF2 (-14), result_hi=0xFFFFFFFE (-2).
  - Also a=100, b=-7 gives lo=-14, hi=2.
- Divide by zero: a=0x1234, b=0.
  - done in cycle 1, lo=0xFFFFFFFF, hi=0x1234, stall_request high for 1 cycle.
- Flush at iteration 10 (cycle 10):
  - stall_request drops to 0 the same cycle, state is IDLE next cycle, done never asserts.
  - A following division (a=9, b=3) returns lo=3, hi=0.
- stall_all held for cycles 33–36:
  - done and results stay stable through cycle 36; IDLE at cycle 37.
- Overflow plus reset:
  - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
  - rst asserted at cycle 15 of a division: all outputs are 0 next cycle.
